// File: rtl/add_accumulator_if.sv
// Stream interface for add_accumulator.
//   Operand side : clear, in_valid, in_ready, in_data, in_last
//   Result side  : out_valid, out_ready, out_sum, out_carry, out_ovf, out_count, busy
//   master modport drives operands and accepts results; slave modport is the accumulator.
interface add_accumulator_if #(
   parameter int CNT_W = 8
);
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_sum;
   logic             out_carry;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;
   logic             busy;

   modport master (
      output clear, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_count, busy
   );

   modport slave (
      input  clear, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_carry, out_ovf, out_count, busy
   );
endinterface

// File: rtl/add_accumulator.sv
// add_accumulator: sums a packet of 16-bit operands through a 16-bit ripple-carry
// adder and presents the total with sticky carry / signed-overflow flags.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : add_accumulator_if.slave (operand stream in, result stream out)
// Optional feature macro ACC_SATURATE_EN: unsigned saturation at 16'hFFFF
// instead of modulo-2^16 wrap.
//
// state | meaning
// IDLE  | no packet in progress, acc/flags/count are zero
// ACCUM | packet started, waiting for further beats
// DONE  | result presented on out_*, waiting for out_ready

module sixteen_bit_full_adder (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] sum_o,
   output logic        carry15_o,
   output logic        carry14_o
);
   logic [16:0] c_w;

   assign c_w[0] = c_i;

   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c_w[i];
      assign c_w[i+1]  = (a_i[i] & b_i[i]) | (c_w[i] & (a_i[i] ^ b_i[i]));
   end

   assign carry15_o = c_w[16];
   assign carry14_o = c_w[15];
endmodule

module add_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   add_accumulator_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;

   logic [15:0]      sum_w;
   logic             carry15_w, carry14_w;
   logic [15:0]      acc_next_w;
   logic [CNT_W-1:0] cnt_inc_w;
   logic             beat_w;

   sixteen_bit_full_adder u_adder (
      .a_i       (acc_q),
      .b_i       (bus.in_data),
      .c_i       (1'b0),
      .sum_o     (sum_w),
      .carry15_o (carry15_w),
      .carry14_o (carry14_w)
   );

   // An overflowing beat pins acc at all-ones; adding anything non-zero to
   // FFFF carries again, so acc stays saturated for the rest of the packet.
`ifdef ACC_SATURATE_EN
   assign acc_next_w = carry15_w ? 16'hFFFF : sum_w;
`else
   assign acc_next_w = sum_w;
`endif

   assign cnt_inc_w = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                                : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   assign bus.in_ready = (state_q != DONE);
   assign bus.busy     = (state_q != IDLE);
   assign beat_w       = bus.in_valid & bus.in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      if (bus.clear) begin
         state_d = IDLE;
         acc_d   = 16'h0000;
         carry_d = 1'b0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (beat_w) begin
                  acc_d   = acc_next_w;
                  carry_d = carry15_w;
                  ovf_d   = carry15_w ^ carry14_w;
                  cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d = bus.in_last ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (beat_w) begin
                  acc_d   = acc_next_w;
                  carry_d = carry_q | carry15_w;
                  ovf_d   = ovf_q | (carry15_w ^ carry14_w);
                  cnt_d   = cnt_inc_w;
                  if (bus.in_last) state_d = DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
                  acc_d   = 16'h0000;
                  carry_d = 1'b0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= 16'h0000;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = acc_q;
   assign bus.out_carry = carry_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_add_accumulator.sv
module tb_add_accumulator;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   add_accumulator_if #(.CNT_W(8)) bus ();

   add_accumulator #(.CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one accepted beat: inputs set just after an edge, held over the next edge.
   task automatic beat(input logic [15:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got rdy=%b busy=%b vld=%b want 1 0 0",
                  bus.in_ready, bus.busy, bus.out_valid);
      end
      checks++;
      if (bus.out_sum !== 16'h0000 || bus.out_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_data got sum=%h cnt=%0d want 0000 0", bus.out_sum, bus.out_count);
      end
   endtask

   task automatic test_basic_sum();
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b0);
      beat(16'h0003, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0006 || bus.out_carry !== 1'b0 ||
          bus.out_ovf !== 1'b0 || bus.out_count !== 8'd3) begin
         errors++;
         $display("FAIL basic_sum got v=%b s=%h c=%b o=%b n=%0d want 1 0006 0 0 3",
                  bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_count);
      end
      consume();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_release got v=%b r=%b b=%b want 0 1 0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_carry_wrap();
      logic [15:0] exp_sum;
`ifdef ACC_SATURATE_EN
      exp_sum = 16'hFFFF;
`else
      exp_sum = 16'h0001;
`endif
      beat(16'hFFFF, 1'b0);
      beat(16'h0002, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.out_carry !== 1'b1 ||
          bus.out_ovf !== 1'b0 || bus.out_count !== 8'd2) begin
         errors++;
         $display("FAIL carry_wrap got v=%b s=%h c=%b o=%b n=%0d want 1 %h 1 0 2",
                  bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_count, exp_sum);
      end
      consume();
   endtask

   task automatic test_signed_ovf();
      beat(16'h7FFF, 1'b0);
      beat(16'h0001, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h8000 || bus.out_carry !== 1'b0 ||
          bus.out_ovf !== 1'b1 || bus.out_count !== 8'd2) begin
         errors++;
         $display("FAIL signed_ovf got v=%b s=%h c=%b o=%b n=%0d want 1 8000 0 1 2",
                  bus.out_valid, bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_count);
      end
      consume();
   endtask

   task automatic test_single_beat();
      beat(16'hABCD, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'hABCD || bus.out_count !== 8'd1) begin
         errors++;
         $display("FAIL single_beat got v=%b s=%h n=%0d want 1 abcd 1",
                  bus.out_valid, bus.out_sum, bus.out_count);
      end
      consume();
   endtask

   task automatic test_backpressure();
      beat(16'h0010, 1'b0);
      beat(16'h0020, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0100;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0030 ||
             bus.out_count !== 8'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_%0d got r=%b v=%b s=%h n=%0d b=%b want 0 1 0030 2 1",
                     i, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_count, bus.busy);
         end
         @(posedge clk);
         #1;
      end
      // out_ready taken with in_valid still high: the beat must not be accepted here.
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.out_count !== 8'd0) begin
         errors++;
         $display("FAIL release got v=%b r=%b b=%b n=%0d want 0 1 0 0",
                  bus.out_valid, bus.in_ready, bus.busy, bus.out_count);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0100 || bus.out_count !== 8'd1) begin
         errors++;
         $display("FAIL after_release got v=%b s=%h n=%0d want 1 0100 1",
                  bus.out_valid, bus.out_sum, bus.out_count);
      end
      consume();
   endtask

   task automatic test_async_reset();
      beat(16'h0011, 1'b0);
      beat(16'h0022, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'h0000 || bus.out_count !== 8'd0 ||
          bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got v=%b s=%h n=%0d b=%b r=%b want 0 0000 0 0 1",
                  bus.out_valid, bus.out_sum, bus.out_count, bus.busy, bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      beat(16'h1234, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h1234 || bus.out_count !== 8'd1 ||
          bus.out_carry !== 1'b0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got v=%b s=%h n=%0d c=%b o=%b want 1 1234 1 0 0",
                  bus.out_valid, bus.out_sum, bus.out_count, bus.out_carry, bus.out_ovf);
      end
      consume();
   endtask

   task automatic test_clear();
      beat(16'h0007, 1'b0);
      bus.clear = 1'b1;
      beat(16'h0009, 1'b1);
      bus.clear = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.out_sum !== 16'h0000 || bus.out_count !== 8'd0) begin
         errors++;
         $display("FAIL clear got v=%b b=%b r=%b s=%h n=%0d want 0 0 1 0000 0",
                  bus.out_valid, bus.busy, bus.in_ready, bus.out_sum, bus.out_count);
      end
      beat(16'h0005, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0005 || bus.out_count !== 8'd1) begin
         errors++;
         $display("FAIL after_clear got v=%b s=%h n=%0d want 1 0005 1",
                  bus.out_valid, bus.out_sum, bus.out_count);
      end
      consume();
   endtask

   task automatic test_count_saturate();
      for (int i = 0; i < 259; i++) beat(16'h0001, 1'b0);
      beat(16'h0001, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0104 || bus.out_count !== 8'd255) begin
         errors++;
         $display("FAIL count_sat got v=%b s=%h n=%0d want 1 0104 255",
                  bus.out_valid, bus.out_sum, bus.out_count);
      end
      consume();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_sum();
      test_carry_wrap();
      test_signed_ovf();
      test_single_beat();
      test_backpressure();
      test_async_reset();
      test_clear();
      test_count_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
